unv_shift_n: RTL and testbench

UNV_SHIFT_N -- requirements
Module: unv_shift_n

---
 rtl/unv_shift_n.sv | 109 ++++++++++
 tb/tb_unv_shift_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unv_shift_n.sv
// Universal shift register with single-step and counted multi-step commands.
// A two-state IDLE/RUN controller repeats a latched shift/rotate mode for in_cnt edges.
module unv_shift_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic [WIDTH-1:0] in_l,
   input  logic             in_sir,
   input  logic             in_sil,
   input  logic [2:0]       in_m,
   input  logic             in_en,
   input  logic             in_start,
   input  logic [CNT_W-1:0] in_cnt,
   output logic [WIDTH-1:0] o_q,
   output logic             o_sor,
   output logic             o_sol,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHR  = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ROL  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] rem;
   logic [2:0]       mode_r;
   logic             busy;
   logic             done;
   logic             start_ok;

   // One step of any mode; the reserved encoding falls through to hold.
   function automatic logic [WIDTH-1:0] step_fn(input logic [2:0]       mode,
                                                input logic [WIDTH-1:0] cur,
                                                input logic             sir,
                                                input logic             sil,
                                                input logic [WIDTH-1:0] ld);
      logic [WIDTH-1:0] nxt;
      // NOTE: nxt gets a value before the case so no path leaves it unassigned.
      nxt = cur;
      case (mode)
         M_SHR:   nxt = {sir, cur[WIDTH-1:1]};
         M_SHL:   nxt = {cur[WIDTH-2:0], sil};
         M_LOAD:  nxt = ld;
         M_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
         M_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         M_ASR:   nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   // Only the repeatable modes with a non-zero count enter RUN.
   assign start_ok = (in_cnt != '0) &&
                     (in_m inside {M_SHR, M_SHL, M_ROR, M_ROL, M_ASR});

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state  <= IDLE;
         q      <= '0;
         rem    <= '0;
         mode_r <= M_HOLD;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (in_start) begin
               if (start_ok) begin
                  mode_r <= in_m;
                  rem    <= in_cnt;
                  state  <= RUN;
                  busy   <= 1'b1;
               end else begin
                  if (in_m == M_LOAD) q <= in_l;
                  done <= 1'b1;
               end
            end else if (in_en) begin
               q <= step_fn(in_m, q, in_sir, in_sil, in_l);
            end
         end else begin
            q   <= step_fn(mode_r, q, in_sir, in_sil, in_l);
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

   assign o_q    = q;
   assign o_sor  = q[0];
   assign o_sol  = q[WIDTH-1];
   assign o_busy = busy;
   assign o_done = done;

endmodule

// File: tb/tb_unv_shift_n.sv
// Scoreboard bench for unv_shift_n: an arithmetic reference model pushes expected
// state per edge; a negedge monitor pops and compares, plus directed known-value checks.
module tb_unv_shift_n;

   localparam int W   = 8;
   localparam int TOP = 1 << (W - 1);
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] l = '0;
   logic         sir = 1'b0;
   logic         sil = 1'b0;
   logic [2:0]   m = '0;
   logic         en = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   cnt = '0;
   logic [W-1:0] o_q;
   logic         o_sor, o_sol, o_busy, o_done;

   typedef struct {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int mq = 0, mrem = 0, mmode = 0;
   bit mrun = 1'b0, mdone = 1'b0;

   unv_shift_n #(.WIDTH(W), .CNT_W(4)) dut (
      .in_clk  (clk),
      .in_rst  (rst),
      .in_l    (l),
      .in_sir  (sir),
      .in_sil  (sil),
      .in_m    (m),
      .in_en   (en),
      .in_start(start),
      .in_cnt  (cnt),
      .o_q     (o_q),
      .o_sor   (o_sor),
      .o_sol   (o_sol),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_step(int mode, int q, int si_r, int si_l, int ld);
      case (mode)
         1:       return (q / 2) + si_r * TOP;
         2:       return ((q * 2) % MOD) + si_l;
         3:       return ld;
         4:       return (q / 2) + (q % 2) * TOP;
         5:       return ((q * 2) % MOD) + (q / TOP);
         6:       return (q / 2) + (q & TOP);
         default: return q;
      endcase
   endfunction

   function automatic void model_reset();
      mq = 0; mrem = 0; mmode = 0; mrun = 1'b0; mdone = 1'b0;
   endfunction

   // Apply the spec rules to the inputs present at this rising edge.
   function automatic void model_edge();
      if (rst) begin
         model_reset();
      end else if (mrun) begin
         mq    = model_step(mmode, mq, int'(sir), int'(sil), int'(l));
         mrem  = mrem - 1;
         mdone = 1'b0;
         if (mrem == 0) begin
            mrun  = 1'b0;
            mdone = 1'b1;
         end
      end else begin
         mdone = 1'b0;
         if (start) begin
            if (int'(cnt) > 0 && (m == 1 || m == 2 || m == 4 || m == 5 || m == 6)) begin
               mrun  = 1'b1;
               mrem  = int'(cnt);
               mmode = int'(m);
            end else begin
               if (m == 3) mq = int'(l);
               mdone = 1'b1;
            end
         end else if (en) begin
            mq = model_step(int'(m), mq, int'(sir), int'(sil), int'(l));
         end
      end
   endfunction

   task automatic drive(input logic e, input logic s, input logic [2:0] mm, input logic [3:0] c,
                        input logic [W-1:0] ld, input logic si_r, input logic si_l);
      @(negedge clk);
      en = e; start = s; m = mm; cnt = c; l = ld; sir = si_r; sil = si_l;
      @(posedge clk);
      model_edge();
      sb.push_back('{q: W'(mq), busy: mrun, done: mdone});
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 3'd0, 4'd0, '0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [W-1:0] v);
      drive(1'b1, 1'b0, 3'b011, 4'd0, v, 1'b0, 1'b0);
   endtask

   task automatic step(input logic [2:0] mm, input logic si_r, input logic si_l);
      drive(1'b1, 1'b0, mm, 4'd0, '0, si_r, si_l);
   endtask

   // Assert reset mid-cycle, check immediately, hold over one edge, then release.
   task automatic reset_pulse();
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      model_reset();
      check("rst_q", o_q, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_sor", o_sor, 0);
      check("rst_sol", o_sol, 0);
      idle();
      #2;
      rst = 1'b0;
   endtask

   // Monitor: compares every presented cycle against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_q", o_q, e.q);
            check("sb_busy", o_busy, e.busy);
            check("sb_done", o_done, e.done);
            check("sb_sor", o_sor, e.q[0]);
            check("sb_sol", o_sol, e.q[W-1]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cycles;
      #1 rst = 1'b1;
      #1;
      check("por_q", o_q, 0);
      check("por_busy", o_busy, 0);
      check("por_done", o_done, 0);
      model_reset();
      idle();
      #2 rst = 1'b0;

      // Single-step sequence
      load(8'hA5);               check("ld_a5", o_q, 8'hA5);
      step(3'b001, 1'b1, 1'b0);  check("shr_d2", o_q, 8'hD2);
      step(3'b010, 1'b0, 1'b0);  check("shl_a4", o_q, 8'hA4);
      step(3'b000, 1'b1, 1'b1);  check("hold_a4", o_q, 8'hA4);

      // Single-step variants
      load(8'h90); step(3'b110, 1'b0, 1'b0); check("asr_c8", o_q, 8'hC8);
      load(8'h81); step(3'b101, 1'b0, 1'b0); check("rol_03", o_q, 8'h03);
      load(8'h81); step(3'b100, 1'b0, 1'b0); check("ror_c0", o_q, 8'hC0);
      step(3'b111, 1'b1, 1'b1);              check("rsv_c0", o_q, 8'hC0);
      drive(1'b0, 1'b0, 3'b011, 4'd0, 8'h55, 1'b1, 1'b1); check("en0_hold", o_q, 8'hC0);

      // Multi-step rotate left x3 with a start pulse during RUN
      load(8'h01);
      drive(1'b0, 1'b1, 3'b101, 4'd3, '0, 1'b0, 1'b0);
      check("ms_latch_q", o_q, 8'h01);
      busy_cycles = int'(o_busy);
      drive(1'b1, 1'b1, 3'b011, 4'd15, 8'hFF, 1'b0, 1'b0);
      check("ms_q1", o_q, 8'h02); busy_cycles += int'(o_busy);
      idle(); check("ms_q2", o_q, 8'h04); busy_cycles += int'(o_busy);
      idle(); check("ms_q3", o_q, 8'h08); busy_cycles += int'(o_busy);
      check("ms_done", o_done, 1);
      check("ms_busy_cycles", busy_cycles, 3);
      idle(); check("ms_done_clr", o_done, 0); check("ms_q_hold", o_q, 8'h08);

      // Zero-count start, then a 12-step fill from 0xFF
      drive(1'b0, 1'b1, 3'b001, 4'd0, '0, 1'b1, 1'b0);
      check("c0_q", o_q, 8'h08); check("c0_busy", o_busy, 0); check("c0_done", o_done, 1);
      idle(); check("c0_done_clr", o_done, 0);
      load(8'hFF);
      drive(1'b0, 1'b1, 3'b010, 4'd12, '0, 1'b0, 1'b0);
      repeat (11) idle();
      check("c12_busy", o_busy, 1);
      idle();
      check("c12_q", o_q, 8'h00); check("c12_busy_end", o_busy, 0); check("c12_done", o_done, 1);

      // Back-to-back: start on the done cycle
      load(8'h81);
      drive(1'b0, 1'b1, 3'b100, 4'd1, '0, 1'b0, 1'b0);
      idle(); check("bb_q1", o_q, 8'hC0); check("bb_done1", o_done, 1);
      drive(1'b0, 1'b1, 3'b101, 4'd1, '0, 1'b0, 1'b0);
      check("bb_busy", o_busy, 1);
      idle(); check("bb_q2", o_q, 8'h81); check("bb_done2", o_done, 1);

      // Abort a run with reset
      load(8'h01);
      drive(1'b0, 1'b1, 3'b100, 4'd5, '0, 1'b0, 1'b0);
      idle(); idle(); check("ab_q2", o_q, 8'h40);
      reset_pulse();
      for (int i = 0; i < 4; i++) begin
         idle();
         check("ab_no_done", o_done, 0);
      end
      load(8'h3C); check("ab_reload", o_q, 8'h3C);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            reset_pulse();
         end else begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end

      repeat (2) @(negedge clk);
      #1;
      check("sb_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
